// File: rtl/simple_cpu_pkg.sv
// Shared constants, opcodes, phase enum and instruction-field positions for
// the simple_cpu core and its phase generator.
package simple_cpu_pkg;

  localparam int DATA_W     = 8;
  localparam int NREGS      = 4;
  localparam int REG_W      = $clog2(NREGS);
  localparam int IMEM_DEPTH = 16;
  localparam int PC_W       = $clog2(IMEM_DEPTH);
  localparam int INSN_W     = 16;

  // Instruction field slice positions; imm8 overlaps the rs2 field.
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS1_MSB = 9;
  localparam int RS1_LSB = 8;
  localparam int RS2_MSB = 7;
  localparam int RS2_LSB = 6;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BEQZ = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    PH_FETCH  = 2'd0,
    PH_DECODE = 2'd1,
    PH_EXEC   = 2'd2,
    PH_WB     = 2'd3
  } phase_e;

  // Opcodes ADD..MOV are exactly the ones that write rd in writeback.
  function automatic logic op_writes_rd(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_MOV);
  endfunction

endpackage

// File: rtl/simple_cpu_phase_gen.sv
// Four-phase sequencer: FETCH -> DECODE -> EXEC -> WB -> FETCH.
// hold_i freezes the phase and suppresses every step strobe.
module simple_cpu_phase_gen
  import simple_cpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   hold_i,
  output phase_e phase_o,
  output logic   step1_o,
  output logic   step2_o,
  output logic   step3_o,
  output logic   step4_o
);

  phase_e phase_q, phase_d;

  // State register.
  // NOTE: clocked blocks use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= PH_FETCH;
    else        phase_q <= phase_d;
  end

  // Next phase: advance every clock unless held.
  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    phase_d = phase_q;
    if (!hold_i) begin
      unique case (phase_q)
        PH_FETCH:  phase_d = PH_DECODE;
        PH_DECODE: phase_d = PH_EXEC;
        PH_EXEC:   phase_d = PH_WB;
        PH_WB:     phase_d = PH_FETCH;
      endcase
    end
  end

  // One-hot step strobes, silenced while held.
  always_comb begin
    phase_o = phase_q;
    step1_o = 1'b0;
    step2_o = 1'b0;
    step3_o = 1'b0;
    step4_o = 1'b0;
    if (!hold_i) begin
      unique case (phase_q)
        PH_FETCH:  step1_o = 1'b1;
        PH_DECODE: step2_o = 1'b1;
        PH_EXEC:   step3_o = 1'b1;
        PH_WB:     step4_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/simple_cpu.sv
// simple_cpu: 4-phase multicycle CPU, 4 x 8-bit registers, 16-word imem.
// Optional feature macro: SIMPLE_CPU_BRANCH_EN enables opcode 9 (BEQZ);
// without it opcode 9 retires as a NOP.
module simple_cpu
  import simple_cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              imem_we,
  input  logic [PC_W-1:0]   imem_addr,
  input  logic [INSN_W-1:0] imem_wdata,
  input  logic [REG_W-1:0]  dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic [PC_W-1:0]   pc,
  output logic [1:0]        phase,
  output logic [DATA_W-1:0] out,
  output logic              halted
);

  logic [INSN_W-1:0] imem_q [IMEM_DEPTH];
  logic [INSN_W-1:0] ir_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              halted_q, halted_d;

  phase_e phase_w;
  logic   step_fetch, step_decode, step_exec, step_wb;

  logic [3:0]        op;
  logic [REG_W-1:0]  rd, rs1, rs2;
  logic [DATA_W-1:0] imm;

  assign op  = ir_q[OP_MSB:OP_LSB];
  assign rd  = ir_q[RD_MSB:RD_LSB];
  assign rs1 = ir_q[RS1_MSB:RS1_LSB];
  assign rs2 = ir_q[RS2_MSB:RS2_LSB];
  assign imm = ir_q[IMM_MSB:IMM_LSB];

  simple_cpu_phase_gen u_phase_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold_i  (halted_q),
    .phase_o (phase_w),
    .step1_o (step_fetch),
    .step2_o (step_decode),
    .step3_o (step_exec),
    .step4_o (step_wb)
  );

  // Host-loaded instruction store; a same-cycle fetch sees the old word.
  // NOTE: no reset on the memory array: contents belong to the host and must survive rst_n.
  always_ff @(posedge clk) begin
    if (imem_we) imem_q[imem_addr] <= imem_wdata;
  end

  // EXEC result: ALU ops, LDI and MOV update out; everything else keeps it.
  always_comb begin
    out_d = out_q;
    case (op)
      OP_ADD:  out_d = a_q + b_q;
      OP_SUB:  out_d = a_q - b_q;
      OP_AND:  out_d = a_q & b_q;
      OP_OR:   out_d = a_q | b_q;
      OP_XOR:  out_d = a_q ^ b_q;
      OP_LDI:  out_d = imm;
      OP_MOV:  out_d = a_q;
      default: out_d = out_q;
    endcase
  end

  // WB control flow: sequential pc, jumps, optional branch, and halt.
  always_comb begin
    pc_d     = pc_q + 1'b1;
    halted_d = halted_q;
    case (op)
      OP_NOP:  pc_d = pc_q + 1'b1;
      OP_JMP:  pc_d = imm[PC_W-1:0];
`ifdef SIMPLE_CPU_BRANCH_EN
      OP_BEQZ: if (a_q == '0) pc_d = imm[PC_W-1:0];
`else
      OP_BEQZ: pc_d = pc_q + 1'b1;
`endif
      OP_HALT: begin
        pc_d     = pc_q;
        halted_d = 1'b1;
      end
      default: pc_d = pc_q + 1'b1;
    endcase
  end

  // Per-phase datapath registers; operands are latched in DECODE so rd may alias rs1/rs2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      out_q    <= '0;
      pc_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      if (step_fetch) ir_q <= imem_q[pc_q];
      if (step_decode) begin
        a_q <= regs_q[rs1];
        b_q <= regs_q[rs2];
      end
      if (step_exec) out_q <= out_d;
      if (step_wb) begin
        pc_q     <= pc_d;
        halted_q <= halted_d;
      end
    end
  end

  // Register file: written only in WB, from the EXEC result held in out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (step_wb && op_writes_rd(op)) begin
      regs_q[rd] <= out_q;
    end
  end

  assign dbg_data = regs_q[dbg_sel];
  assign pc       = pc_q;
  assign phase    = phase_w;
  assign out      = out_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_simple_cpu.sv
// Scoreboard bench for simple_cpu: an instruction-level model pushes the
// architectural state expected after each retired instruction; a monitor
// pops and compares on every observed retirement (phase WB -> FETCH).
`timescale 1ns/1ps
module tb_simple_cpu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_we = 1'b0;
  logic [3:0]  imem_addr = '0;
  logic [15:0] imem_wdata = '0;
  logic [1:0]  dbg_sel = '0;
  logic [7:0]  dbg_data;
  logic [3:0]  pc;
  logic [1:0]  phase;
  logic [7:0]  out;
  logic        halted;

  simple_cpu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data),
    .pc         (pc),
    .phase      (phase),
    .out        (out),
    .halted     (halted)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [3:0]      pc;
    logic [7:0]      out;
    logic            halted;
    logic [3:0][7:0] regs;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          retired_cnt = 0;
  logic [15:0] prog_buf [16];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs1, input logic [7:0] low);
    return {op, rd, rs1, low};
  endfunction

  // ---------------- monitor ----------------
  logic [1:0] m_prev_phase = '0;
  logic [3:0] m_prev_pc = '0;
  logic       m_prev_halted = 1'b0;
  logic       m_prev_rst = 1'b0;
  logic       m_in_reset = 1'b0;
  logic       m_retire;
  logic [1:0] s_phase;
  logic [3:0] s_pc;
  logic [7:0] s_out;
  logic       s_halted;
  logic       s_rst;
  logic [7:0] s_regs [4];
  exp_t       m_e;

  initial begin : monitor
    forever begin
      @(negedge clk);
      s_phase = phase; s_pc = pc; s_out = out; s_halted = halted; s_rst = rst_n;
      for (int i = 0; i < 4; i++) begin
        dbg_sel = 2'(i);
        #1;
        s_regs[i] = dbg_data;
      end
      if (!s_rst) begin
        if (!m_in_reset) begin
          check("rst_pc", s_pc, 0);
          check("rst_phase", s_phase, 0);
          check("rst_out", s_out, 0);
          check("rst_halted", s_halted, 0);
          for (int i = 0; i < 4; i++) check($sformatf("rst_r%0d", i), s_regs[i], 0);
          sb.delete();
        end
        m_in_reset = 1'b1;
      end else begin
        m_in_reset = 1'b0;
        if (m_prev_rst) begin
          m_retire = (m_prev_phase == 2'd3) && (s_phase == 2'd0) && !m_prev_halted;
          if (m_prev_halted) begin
            check("halt_phase", s_phase, 0);
            check("halt_pc", s_pc, m_prev_pc);
            check("halt_sticky", s_halted, 1);
          end else begin
            check("phase_seq", s_phase, (int'(m_prev_phase) + 1) % 4);
            if (!m_retire) check("pc_hold", s_pc, m_prev_pc);
          end
          if (m_retire) begin
            retired_cnt++;
            if (sb.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL retire: retirement at pc %0d with no expectation queued", s_pc);
            end else begin
              m_e = sb.pop_front();
              check("pc", s_pc, m_e.pc);
              check("out", s_out, m_e.out);
              check("halted", s_halted, m_e.halted);
              for (int i = 0; i < 4; i++) check($sformatf("r%0d", i), s_regs[i], m_e.regs[i]);
            end
          end
        end
      end
      m_prev_phase = s_phase; m_prev_pc = s_pc; m_prev_halted = s_halted; m_prev_rst = s_rst;
    end
  end

  // ---------------- reference model ----------------
  // Executes prog_buf one instruction at a time from the ISA rules and
  // queues the state expected after each retirement.
  task automatic model_run(input int n_max, output int n_exp, output bit halts);
    int r [4];
    int pc_m, out_m, w, op, rd, rs1, rs2, imm, nxt;
    exp_t e;
    r = '{0, 0, 0, 0};
    pc_m = 0; out_m = 0; halts = 1'b0; n_exp = 0;
    for (int k = 0; k < n_max && !halts; k++) begin
      w   = int'(prog_buf[pc_m]);
      op  = (w >> 12) & 15;
      rd  = (w >> 10) & 3;
      rs1 = (w >> 8) & 3;
      rs2 = (w >> 6) & 3;
      imm = w & 255;
      nxt = (pc_m + 1) % 16;
      case (op)
        1: begin out_m = (r[rs1] + r[rs2]) % 256;       r[rd] = out_m; end
        2: begin out_m = (r[rs1] - r[rs2] + 256) % 256; r[rd] = out_m; end
        3: begin out_m = r[rs1] & r[rs2];               r[rd] = out_m; end
        4: begin out_m = r[rs1] | r[rs2];               r[rd] = out_m; end
        5: begin out_m = r[rs1] ^ r[rs2];               r[rd] = out_m; end
        6: begin out_m = imm;                           r[rd] = out_m; end
        7: begin out_m = r[rs1];                        r[rd] = out_m; end
        8: nxt = imm % 16;
        9: begin
`ifdef SIMPLE_CPU_BRANCH_EN
          if (r[rs1] == 0) nxt = imm % 16;
`endif
        end
        15: begin halts = 1'b1; nxt = pc_m; end
        default: ;
      endcase
      pc_m = nxt;
      e.pc = 4'(pc_m); e.out = 8'(out_m); e.halted = halts;
      for (int i = 0; i < 4; i++) e.regs[i] = 8'(r[i]);
      sb.push_back(e);
      n_exp++;
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int a = 0; a < 16; a++) prog_buf[a] = 16'h0000;
  endtask

  // Reset, load prog_buf, queue the expectations, release reset.
  task automatic start_prog(input int n_max, output int n_exp, output bit halts, output int base);
    tick();
    rst_n = 1'b0;
    tick();
    for (int a = 0; a < 16; a++) begin
      imem_we = 1'b1; imem_addr = 4'(a); imem_wdata = prog_buf[a];
      tick();
    end
    imem_we = 1'b0;
    model_run(n_max, n_exp, halts);
    base = retired_cnt;
    rst_n = 1'b1;
  endtask

  task automatic wait_retire(input int n_exp, input int base);
    int cyc = 0;
    while ((retired_cnt - base) < n_exp && cyc < n_exp * 4 + 40) begin
      tick();
      cyc++;
    end
    check("retired_count", retired_cnt - base, n_exp);
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic run_prog(input string name, input int n_max);
    int n_exp, base;
    bit halts;
    start_prog(n_max, n_exp, halts, base);
    wait_retire(n_exp, base);
    if (halts) begin
      repeat (8) tick();
      check({name, "_halted_pin"}, halted, 1);
    end
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n_exp, base, cyc;
    bit halts;
    logic [15:0] w;
    #2 rst_n = 1'b0;

    // Four LDIs then HALT: regs 4,2,2,4, pc parks at 4.
    clear_prog();
    prog_buf[0] = enc(4'h6, 2'd0, 2'd0, 8'd4);
    prog_buf[1] = enc(4'h6, 2'd1, 2'd0, 8'd2);
    prog_buf[2] = enc(4'h6, 2'd2, 2'd0, 8'd2);
    prog_buf[3] = enc(4'h6, 2'd3, 2'd0, 8'd4);
    prog_buf[4] = enc(4'hF, 2'd0, 2'd0, 8'd0);
    run_prog("ldi", 10);
    check("ldi_pc", pc, 4);

    // ADD/SUB wrap modulo 256.
    clear_prog();
    prog_buf[0] = enc(4'h6, 2'd0, 2'd0, 8'd250);
    prog_buf[1] = enc(4'h6, 2'd1, 2'd0, 8'd10);
    prog_buf[2] = enc(4'h1, 2'd2, 2'd0, {2'd1, 6'd0});
    prog_buf[3] = enc(4'h2, 2'd3, 2'd1, {2'd0, 6'd0});
    prog_buf[4] = enc(4'hF, 2'd0, 2'd0, 8'd0);
    run_prog("wrap", 10);

    // rd aliasing both sources, then JMP 0 reruns from the LDI.
    clear_prog();
    prog_buf[0] = enc(4'h6, 2'd0, 2'd0, 8'd4);
    prog_buf[1] = enc(4'h1, 2'd0, 2'd0, {2'd0, 6'd0});
    prog_buf[2] = enc(4'h8, 2'd0, 2'd0, 8'd0);
    run_prog("hazard", 7);

    // Sixteen NOPs: pc wraps 15 -> 0 and never halts.
    clear_prog();
    run_prog("pcwrap", 18);

    // BEQZ r3 (zero) to 5: taken only with the branch feature.
    clear_prog();
    prog_buf[0] = enc(4'h9, 2'd0, 2'd3, 8'd5);
    prog_buf[1] = enc(4'hF, 2'd0, 2'd0, 8'd0);
    prog_buf[5] = enc(4'hF, 2'd0, 2'd0, 8'd0);
    run_prog("beqz", 4);

    // Reset during EXEC of ADD r0,r1,r2: no write, pc and phase back to 0.
    clear_prog();
    prog_buf[0] = enc(4'h6, 2'd1, 2'd0, 8'd3);
    prog_buf[1] = enc(4'h6, 2'd2, 2'd0, 8'd5);
    prog_buf[2] = enc(4'h1, 2'd0, 2'd1, {2'd2, 6'd0});
    prog_buf[3] = enc(4'hF, 2'd0, 2'd0, 8'd0);
    start_prog(2, n_exp, halts, base);
    wait_retire(n_exp, base);
    cyc = 0;
    while (phase != 2'd2 && cyc < 8) begin
      tick();
      cyc++;
    end
    check("midrst_in_exec", phase, 2);
    rst_n = 1'b0;
    #1;
    check("midrst_pc", pc, 0);
    check("midrst_phase", phase, 0);
    check("midrst_out", out, 0);
    tick();

    // Randomised programs, LDI-biased so the ALU sees non-zero operands.
    for (int t = 0; t < 8; t++) begin
      for (int a = 0; a < 16; a++) begin
        w = 16'($urandom());
        if ($urandom_range(0, 2) == 0) w[15:12] = 4'h6;
        prog_buf[a] = w;
      end
      run_prog("rand", 20);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
